mem_write_checker: RTL and testbench
====================================

// Module: mem_write_checker
// PURPOSE
//  Synthesizable, parametrised pass/fail monitor on the CPU data-memory write port (write_data, data_memory_addr, mem_write).
//  Loaded with a table of expected (addr,data) writes; ignores writes inside a scratch window; flags first illegal write or timeout.
//  Sits beside Top in benches and FPGA bring-up; replaces hard-coded single "addr 100 == 7" success checks.
// PARAMETERS
//  ADDR_WIDTH      32     width of data_memory_addr
//  DATA_WIDTH      32     width of write_data
//  NUM_EXPECT      8      expectation-table depth (>=1)
//  SCRATCH_BASE    96     first address of tolerated scratch window
//  SCRATCH_SIZE    4      window size in bytes; 0 disables window
//  TIMEOUT_CYCLES  10000  RUN cycles before TIMEOUT failure; 0 disables timeout
// PORTS
//  clk               in   1                      clock, all logic on posedge
//  reset             in   1                      synchronous, active-high
//  exp_we            in   1                      write one table entry (IDLE only)
//  exp_idx           in   $clog2(NUM_EXPECT)     entry index
//  exp_addr          in   ADDR_WIDTH             expected address
//  exp_data          in   DATA_WIDTH             expected data
//  exp_count         in   $clog2(NUM_EXPECT+1)   number of entries to check, sampled on start
//  start             in   1                      IDLE -> RUN
//  mem_write         in   1                      monitored write strobe
//  data_memory_addr  in   ADDR_WIDTH             monitored address
//  write_data        in   DATA_WIDTH             monitored data
//  done              out  1                      PASS or FAIL reached (sticky)
//  pass              out  1                      1 = all expected writes seen
//  fail_code         out  2                      fail_code_t: NONE/UNEXPECTED_ADDR/DATA_MISMATCH/TIMEOUT
//  fail_addr         out  ADDR_WIDTH             address of offending write (0 for TIMEOUT)
//  fail_data         out  DATA_WIDTH             data of offending write (0 for TIMEOUT)
//  match_count       out  $clog2(NUM_EXPECT+1)   expected writes matched so far
//  cycle_count       out  32                     RUN cycles elapsed, frozen at done
// BEHAVIOUR
//  Reset: state=IDLE; done=pass=0; fail_code=NONE; fail_addr=fail_data=0; match_count=cycle_count=0; table entries cleared to 0.
//  FSM IDLE -> RUN on start (latches exp_count, clears counters); RUN -> PASS | FAIL; PASS/FAIL sticky until reset.
//  exp_we honoured only in IDLE; ignored in RUN/PASS/FAIL. start outside IDLE ignored. exp_count > NUM_EXPECT clamped to NUM_EXPECT.
//  exp_count==0: PASS one cycle after start.
//  RUN, each cycle with mem_write=1, priority order:
//   1. addr==exp_addr[match_count] && data==exp_data[match_count] -> match_count++; if new count==exp_count -> PASS.
//   2. addr==exp_addr[match_count], data differs -> FAIL DATA_MISMATCH.
//   3. SCRATCH_BASE <= addr < SCRATCH_BASE+SCRATCH_SIZE -> ignored.
//   4. otherwise -> FAIL UNEXPECTED_ADDR.
//  On FAIL, fail_addr/fail_data capture the offending write. Any X/Z on addr/data while mem_write=1 treated as UNEXPECTED_ADDR in sim.
//  cycle_count increments every RUN cycle; if it reaches TIMEOUT_CYCLES-1 with no completion -> FAIL TIMEOUT.
//  Simultaneous completing match and timeout in same cycle -> PASS wins.
//  Latency: done/pass/fail_code registered, valid the cycle after the deciding write (1-cycle latency).
//  Outputs held stable while done=1; mem_write ignored after done.
//  Reset mid-RUN: returns to IDLE with reset values above; table must be reloaded.
// CONFIGURATION
//  CHECKER_UNORDERED_EN defined: expected entries may match in any order; a hit-bitmask (NUM_EXPECT bits) replaces the in-order pointer.
//   Rule 1/2 compare against all unhit entries among first exp_count; data mismatch only if addr hits an unhit entry and no unhit
//   entry matches both; already-hit addr re-written -> UNEXPECTED_ADDR unless in scratch window. match_count = popcount(mask).
//  Not defined: strict in-order matching as above.
// STRUCTURE
//  Package mem_checker_pkg: typedef enum logic [1:0] state_t {IDLE, RUN, PASS, FAIL}; enum fail_code_t {NONE, UNEXPECTED_ADDR,
//   DATA_MISMATCH, TIMEOUT}; struct expect_entry_t {addr, data}.
//  Sub-module expect_table: NUM_EXPECT-entry register array with synchronous write port and combinational read/compare outputs.
//  mem_write_checker holds FSM, counters, scratch-window decode and fail capture.
// TESTING
//  1. Load (100,7), exp_count=1, start; write (96,5) then (100,7) -> pass=1,done=1 next cycle, match_count=1, fail_code=NONE.
//  2. Load (100,7); write (104,3) -> FAIL UNEXPECTED_ADDR, fail_addr=104, fail_data=3; later (100,7) has no effect.
//  3. Load (100,7); write (100,6) -> FAIL DATA_MISMATCH, fail_data=6.
//  4. TIMEOUT_CYCLES=50, no writes after start -> FAIL TIMEOUT with cycle_count=49; completing match on that cycle -> PASS.
//  5. Load (80,1),(84,2), exp_count=2; write (84,2),(80,1) -> FAIL UNEXPECTED_ADDR fail_addr=84; with CHECKER_UNORDERED_EN -> PASS.
//  6. Reset asserted mid-RUN after one match -> next cycle IDLE, match_count=0, done=0; exp_count=0 + start -> PASS next cycle.

Source files
------------

// File: rtl/mem_checker_pkg.sv
// Shared types for the data-memory write checker: FSM states, failure codes
// and the expectation-table entry layout.
package mem_checker_pkg;

  typedef enum logic [1:0] {IDLE, RUN, PASS, FAIL} state_t;

  typedef enum logic [1:0] {NONE, UNEXPECTED_ADDR, DATA_MISMATCH, TIMEOUT} fail_code_t;

  // Entries are stored at a fixed maximum width; narrower buses are zero-extended.
  localparam int ENTRY_AW = 64;
  localparam int ENTRY_DW = 64;

  typedef struct packed {
    logic [ENTRY_AW-1:0] addr;
    logic [ENTRY_DW-1:0] data;
  } expect_entry_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_write_checker_expect_table.sv
// Expectation table: NUM_EXPECT (addr,data) registers with a synchronous write
// port and per-entry combinational address / address+data hit vectors.
module expect_table
  import mem_checker_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_EXPECT = 8,
  localparam int IDX_W = idx_width(NUM_EXPECT)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [IDX_W-1:0]      idx,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] cmp_addr,
  input  logic [DATA_WIDTH-1:0] cmp_data,
  output logic [NUM_EXPECT-1:0] addr_hit,
  output logic [NUM_EXPECT-1:0] full_hit
);

  expect_entry_t table_q [NUM_EXPECT];

  // NOTE: this array is reset explicitly because a cleared table is part of the
  // post-reset state; plain storage arrays normally stay unreset so they map to RAM.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_EXPECT; i++) table_q[i] <= '0;
    end else if (we && (int'(idx) < NUM_EXPECT)) begin
      // NOTE: non-blocking assignment for all clocked state avoids update-order races.
      table_q[idx] <= '{addr: ENTRY_AW'(wr_addr), data: ENTRY_DW'(wr_data)};
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_EXPECT; i++) begin
      addr_hit[i] = (table_q[i].addr == ENTRY_AW'(cmp_addr));
      full_hit[i] = addr_hit[i] && (table_q[i].data == ENTRY_DW'(cmp_data));
    end
  end

endmodule

// File: rtl/mem_write_checker.sv
// Pass/fail monitor on the CPU data-memory write port. Define CHECKER_UNORDERED_EN
// to let expected writes complete in any order (hit mask instead of in-order pointer).
module mem_write_checker
  import mem_checker_pkg::*;
#(
  parameter int          ADDR_WIDTH     = 32,
  parameter int          DATA_WIDTH     = 32,
  parameter int          NUM_EXPECT     = 8,
  parameter int unsigned SCRATCH_BASE   = 96,
  parameter int unsigned SCRATCH_SIZE   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 10000,
  localparam int IDX_W = idx_width(NUM_EXPECT),
  localparam int CNT_W = $clog2(NUM_EXPECT + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  exp_we,
  input  logic [IDX_W-1:0]      exp_idx,
  input  logic [ADDR_WIDTH-1:0] exp_addr,
  input  logic [DATA_WIDTH-1:0] exp_data,
  input  logic [CNT_W-1:0]      exp_count,
  input  logic                  start,
  input  logic                  mem_write,
  input  logic [ADDR_WIDTH-1:0] data_memory_addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic                  done,
  output logic                  pass,
  output logic [1:0]            fail_code,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [DATA_WIDTH-1:0] fail_data,
  output logic [CNT_W-1:0]      match_count,
  output logic [31:0]           cycle_count
);

  localparam logic [ADDR_WIDTH:0] SCR_LO   = (ADDR_WIDTH+1)'(SCRATCH_BASE);
  localparam logic [ADDR_WIDTH:0] SCR_HI   = SCR_LO + (ADDR_WIDTH+1)'(SCRATCH_SIZE);
  localparam logic [31:0]         TO_LIMIT = (TIMEOUT_CYCLES == 0) ? 32'd0 : 32'(TIMEOUT_CYCLES - 1);

  state_t                state_q, state_d;
  fail_code_t            fail_code_q, fail_code_d;
  logic [CNT_W-1:0]      exp_count_q, exp_count_d;
  logic [CNT_W-1:0]      match_count_q, match_count_d;
  logic [31:0]           cycle_q, cycle_d;
  logic [ADDR_WIDTH-1:0] fail_addr_q, fail_addr_d;
  logic [DATA_WIDTH-1:0] fail_data_q, fail_data_d;

  logic [NUM_EXPECT-1:0] addr_hit, full_hit;
  logic [CNT_W-1:0]      count_clamped;
  logic                  hit_full, hit_addr, in_scratch, wr_unknown;

  expect_table #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_EXPECT (NUM_EXPECT)
  ) u_table (
    .clk      (clk),
    .reset    (reset),
    .we       (exp_we && (state_q == IDLE)),
    .idx      (exp_idx),
    .wr_addr  (exp_addr),
    .wr_data  (exp_data),
    .cmp_addr (data_memory_addr),
    .cmp_data (write_data),
    .addr_hit (addr_hit),
    .full_hit (full_hit)
  );

  assign count_clamped = (exp_count > CNT_W'(NUM_EXPECT)) ? CNT_W'(NUM_EXPECT) : exp_count;
  assign in_scratch    = (SCRATCH_SIZE != 0) &&
                         ({1'b0, data_memory_addr} >= SCR_LO) &&
                         ({1'b0, data_memory_addr} <  SCR_HI);

`ifndef SYNTHESIS
  assign wr_unknown = $isunknown({data_memory_addr, write_data});
`else
  assign wr_unknown = 1'b0;
`endif

`ifdef CHECKER_UNORDERED_EN
  logic [NUM_EXPECT-1:0] mask_q, mask_d, active, cand_full, cand_addr;

  always_comb begin
    for (int i = 0; i < NUM_EXPECT; i++) active[i] = (int'(exp_count_q) > i);
    cand_full = active & ~mask_q & full_hit;
    cand_addr = active & ~mask_q & addr_hit;
    hit_full  = |cand_full;
    hit_addr  = |cand_addr;
  end

  // A write retires only the lowest matching entry, so duplicates need duplicate writes.
  always_comb begin
    mask_d = mask_q;
    if (state_q == IDLE && start) mask_d = '0;
    else if (state_q == RUN && mem_write && !wr_unknown && hit_full)
      mask_d = mask_q | (cand_full & (~cand_full + 1'b1));
  end

  always_ff @(posedge clk) begin
    if (reset) mask_q <= '0;
    else       mask_q <= mask_d;
  end
`else
  assign hit_full = full_hit[match_count_q[IDX_W-1:0]];
  assign hit_addr = addr_hit[match_count_q[IDX_W-1:0]];
`endif

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d       = state_q;
    fail_code_d   = fail_code_q;
    exp_count_d   = exp_count_q;
    match_count_d = match_count_q;
    cycle_d       = cycle_q;
    fail_addr_d   = fail_addr_q;
    fail_data_d   = fail_data_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          exp_count_d   = count_clamped;
          match_count_d = '0;
          cycle_d       = '0;
          state_d       = (count_clamped == '0) ? PASS : RUN;
        end
      end
      RUN: begin
        cycle_d = cycle_q + 32'd1;
        if (mem_write && !wr_unknown && hit_full) begin
          match_count_d = match_count_q + 1'b1;
          if (match_count_d == exp_count_q) state_d = PASS;
        end else if (mem_write && (wr_unknown || hit_addr || !in_scratch)) begin
          state_d     = FAIL;
          fail_code_d = (!wr_unknown && hit_addr) ? DATA_MISMATCH : UNEXPECTED_ADDR;
          fail_addr_d = data_memory_addr;
          fail_data_d = write_data;
        end
        // Timeout only applies when this cycle neither completed nor failed.
        if (state_d == RUN && TIMEOUT_CYCLES != 0 && cycle_d >= TO_LIMIT) begin
          state_d     = FAIL;
          fail_code_d = TIMEOUT;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      fail_code_q   <= NONE;
      exp_count_q   <= '0;
      match_count_q <= '0;
      cycle_q       <= '0;
      fail_addr_q   <= '0;
      fail_data_q   <= '0;
    end else begin
      state_q       <= state_d;
      fail_code_q   <= fail_code_d;
      exp_count_q   <= exp_count_d;
      match_count_q <= match_count_d;
      cycle_q       <= cycle_d;
      fail_addr_q   <= fail_addr_d;
      fail_data_q   <= fail_data_d;
    end
  end

  assign done        = (state_q == PASS) || (state_q == FAIL);
  assign pass        = (state_q == PASS);
  assign fail_code   = fail_code_q;
  assign fail_addr   = fail_addr_q;
  assign fail_data   = fail_data_q;
  assign match_count = match_count_q;
  assign cycle_count = cycle_q;

endmodule

// File: tb/tb_mem_write_checker.sv
// Directed self-checking bench for mem_write_checker (TIMEOUT_CYCLES = 50).
module tb_mem_write_checker;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          exp_we;
  logic [2:0]    exp_idx;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_data;
  logic [3:0]    exp_count;
  logic          start;
  logic          mem_write;
  logic [AW-1:0] data_memory_addr;
  logic [DW-1:0] write_data;
  logic          done, pass;
  logic [1:0]    fail_code;
  logic [AW-1:0] fail_addr;
  logic [DW-1:0] fail_data;
  logic [3:0]    match_count;
  logic [31:0]   cycle_count;

  int n_checks = 0;
  int n_fail   = 0;

  mem_write_checker #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .NUM_EXPECT     (8),
    .SCRATCH_BASE   (96),
    .SCRATCH_SIZE   (4),
    .TIMEOUT_CYCLES (50)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .exp_we           (exp_we),
    .exp_idx          (exp_idx),
    .exp_addr         (exp_addr),
    .exp_data         (exp_data),
    .exp_count        (exp_count),
    .start            (start),
    .mem_write        (mem_write),
    .data_memory_addr (data_memory_addr),
    .write_data       (write_data),
    .done             (done),
    .pass             (pass),
    .fail_code        (fail_code),
    .fail_addr        (fail_addr),
    .fail_data        (fail_data),
    .match_count      (match_count),
    .cycle_count      (cycle_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic load(input int idx, input int addr, input int data);
    exp_we = 1'b1; exp_idx = 3'(idx); exp_addr = AW'(addr); exp_data = DW'(data);
    tick();
    exp_we = 1'b0;
  endtask

  task automatic run(input int cnt);
    exp_count = 4'(cnt); start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wr(input int addr, input int data);
    mem_write = 1'b1; data_memory_addr = AW'(addr); write_data = DW'(data);
    tick();
    mem_write = 1'b0;
  endtask

  task automatic check_status(input string tag, input int d, input int p, input int fc);
    check({tag, ".done"}, 64'(done), 64'(d));
    check({tag, ".pass"}, 64'(pass), 64'(p));
    check({tag, ".fail_code"}, 64'(fail_code), 64'(fc));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; exp_we = 1'b0; exp_idx = '0; exp_addr = '0; exp_data = '0;
    exp_count = '0; start = 1'b0; mem_write = 1'b0; data_memory_addr = '0; write_data = '0;
    do_reset();

    // Reset state
    check_status("rst", 0, 0, 0);
    check("rst.fail_addr", 64'(fail_addr), 0);
    check("rst.fail_data", 64'(fail_data), 0);
    check("rst.match", 64'(match_count), 0);
    check("rst.cycles", 64'(cycle_count), 0);

    // 1: scratch write ignored, then the expected write passes
    load(0, 100, 7); run(1);
    check_status("t1.run", 0, 0, 0);
    wr(96, 5);
    check_status("t1.scratch", 0, 0, 0);
    wr(100, 7);
    check_status("t1.pass", 1, 1, 0);
    check("t1.match", 64'(match_count), 1);
    check("t1.cycles", 64'(cycle_count), 2);
    tick();
    check("t1.frozen", 64'(cycle_count), 2);

    // 2: unexpected address, later correct write has no effect
    do_reset(); load(0, 100, 7); run(1);
    wr(104, 3);
    check_status("t2.fail", 1, 0, 1);
    check("t2.fail_addr", 64'(fail_addr), 104);
    check("t2.fail_data", 64'(fail_data), 3);
    wr(100, 7);
    check_status("t2.sticky", 1, 0, 1);
    check("t2.match", 64'(match_count), 0);
    check("t2.addr_held", 64'(fail_addr), 104);

    // 3: data mismatch
    do_reset(); load(0, 100, 7); run(1);
    wr(100, 6);
    check_status("t3.fail", 1, 0, 2);
    check("t3.fail_addr", 64'(fail_addr), 100);
    check("t3.fail_data", 64'(fail_data), 6);

    // 4a: timeout at cycle_count 49
    do_reset(); load(0, 100, 7); run(1);
    repeat (48) tick();
    check("t4a.not_yet", 64'(done), 0);
    check("t4a.c48", 64'(cycle_count), 48);
    tick();
    check_status("t4a.timeout", 1, 0, 3);
    check("t4a.cycles", 64'(cycle_count), 49);
    check("t4a.fail_addr", 64'(fail_addr), 0);
    check("t4a.fail_data", 64'(fail_data), 0);

    // 4b: completing match on the timeout cycle wins
    do_reset(); load(0, 100, 7); run(1);
    repeat (48) tick();
    wr(100, 7);
    check_status("t4b.pass", 1, 1, 0);
    check("t4b.cycles", 64'(cycle_count), 49);

    // 5a: out-of-order writes
    do_reset(); load(0, 80, 1); load(1, 84, 2); run(2);
    wr(84, 2);
`ifdef CHECKER_UNORDERED_EN
    check_status("t5a.first", 0, 0, 0);
    check("t5a.match1", 64'(match_count), 1);
    wr(80, 1);
    check_status("t5a.pass", 1, 1, 0);
    check("t5a.match2", 64'(match_count), 2);
`else
    check_status("t5a.fail", 1, 0, 1);
    check("t5a.fail_addr", 64'(fail_addr), 84);
    check("t5a.fail_data", 64'(fail_data), 2);
`endif

    // 5b: in-order writes pass in both builds
    do_reset(); load(0, 80, 1); load(1, 84, 2); run(2);
    wr(80, 1);
    check("t5b.match1", 64'(match_count), 1);
    wr(84, 2);
    check_status("t5b.pass", 1, 1, 0);
    check("t5b.match2", 64'(match_count), 2);

    // Scratch window boundaries: 99 tolerated, 95 rejected
    do_reset(); load(0, 100, 7); run(1);
    wr(99, 1);
    check_status("scr.top", 0, 0, 0);
    wr(95, 1);
    check_status("scr.below", 1, 0, 1);
    check("scr.fail_addr", 64'(fail_addr), 95);

    // Table writes during RUN are ignored
    do_reset(); load(0, 100, 7); run(1);
    load(0, 100, 9);
    wr(100, 7);
    check_status("we_run.pass", 1, 1, 0);

    // 6: reset mid-RUN after one match, then empty run
    do_reset(); load(0, 100, 7); load(1, 104, 8); run(2);
    wr(100, 7);
    check("t6.match1", 64'(match_count), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t6.done", 64'(done), 0);
    check("t6.match0", 64'(match_count), 0);
    run(0);
    check_status("t6.empty_pass", 1, 1, 0);

    // Table cleared by reset: old entry (100,7) is gone
    do_reset(); run(1);
    wr(100, 7);
    check_status("t6.cleared", 1, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
